// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the shift arbiter and its rotator.
package shift_arbiter_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_AMT_W = 8;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/barrel_rotate.sv
// Combinational barrel rotator: log2(WIDTH) power-of-two left-rotate stages.
module barrel_rotate
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] amt,
    input  logic                     dir,
    output logic [WIDTH-1:0]         result
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  neg_amt;
    logic [SH_W-1:0]  left_amt;
    logic [WIDTH-1:0] stage [SH_W+1];

    // A right rotate by a equals a left rotate by (WIDTH - a) mod WIDTH.
    assign neg_amt  = ~amt + 1'b1;
    assign left_amt = (dir == DIR_RIGHT) ? neg_amt : amt;
    assign stage[0] = data;

    for (genvar i = 0; i < SH_W; i++) begin : g_stage
        assign stage[i+1] = left_amt[i]
            ? ((stage[i] << (2**i)) | (stage[i] >> (WIDTH - 2**i)))
            : stage[i];
    end

    assign result = stage[SH_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding a shared barrel rotator into a single-entry
// result register with valid/ready backpressure.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AMT_W = DEF_AMT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ*AMT_W-1:0]   req_amt,
    input  logic [N_REQ-1:0]         req_dir,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned SH_W = $clog2(WIDTH);

    state_e           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic             gnt_any;
    logic             slot_free;
    logic             grant;
    int unsigned      scan_idx;
    logic [WIDTH-1:0] sel_data;
    logic [SH_W-1:0]  sel_amt;
    logic             sel_dir;
    logic [WIDTH-1:0] rot_data;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (32'(rr_ptr) + k) % N_REQ;
            cand     = ID_W'(scan_idx);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign slot_free = !rsp_valid || rsp_ready;
    assign grant     = gnt_any && slot_free && !rst;
    assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

    // Only the low log2(WIDTH) amount bits matter: rotation is mod WIDTH.
    assign sel_data = req_data[32'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_amt  = SH_W'(req_amt >> (32'(gnt_idx)*AMT_W));
    assign sel_dir  = req_dir[gnt_idx];

    barrel_rotate #(
        .WIDTH(WIDTH)
    ) u_rotate (
        .data   (sel_data),
        .amt    (sel_amt),
        .dir    (sel_dir),
        .result (rot_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (grant) begin
                rsp_data <= rot_data;
                rsp_id   <= gnt_idx;
                rr_ptr   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            case (state)
                ST_EMPTY: begin
                    if (grant) begin
                        state     <= ST_FULL;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (rsp_ready && !grant) begin
                        state     <= ST_EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: rotation, modulo amounts, fairness,
// backpressure, sparse traffic and mid-stream reset.
module tb_shift_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [31:0]  req_amt;
    logic [3:0]   req_dir;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] D = 32'h23832CD0;

    shift_arbiter #(
        .N_REQ(4),
        .WIDTH(32),
        .AMT_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d,
                           input logic [7:0] a, input logic dr);
        req_valid[i]         = v;
        req_data[i*32 +: 32] = d;
        req_amt[i*8 +: 8]    = a;
        req_dir[i]           = dr;
    endtask

    initial begin
        int exp_id;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        tick();

        // Basic rotate left by 4 from requester 0
        set_req(0, 1'b1, D, 8'd4, 1'b0);
        #1;
        chk("rot_ready", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, D, 8'd4, 1'b0);
        chk("rot_valid", 32'(rsp_valid), 32'd1);
        chk("rot_data", rsp_data, 32'h3832CD02);
        chk("rot_id", 32'(rsp_id), 32'd0);
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        chk("drain_hold", rsp_data, 32'h3832CD02);

        // Direction / modulo: back-to-back, pointer walks 1,2,3,0
        set_req(1, 1'b1, D, 8'd8, 1'b1);
        #1;
        chk("r8_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("r8_data", rsp_data, 32'hD023832C);
        chk("r8_id", 32'(rsp_id), 32'd1);
        set_req(1, 1'b0, D, 8'd8, 1'b1);
        set_req(2, 1'b1, D, 8'd36, 1'b0);
        #1;
        chk("l36_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("l36_data", rsp_data, 32'h3832CD02);
        chk("l36_id", 32'(rsp_id), 32'd2);
        set_req(2, 1'b0, D, 8'd36, 1'b0);
        set_req(3, 1'b1, D, 8'd0, 1'b0);
        #1;
        chk("a0_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("a0_data", rsp_data, D);
        chk("a0_valid", 32'(rsp_valid), 32'd1);
        set_req(3, 1'b0, D, 8'd0, 1'b0);
        set_req(0, 1'b1, D, 8'd32, 1'b1);
        #1;
        chk("a32_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("a32_data", rsp_data, D);
        chk("a32_id", 32'(rsp_id), 32'd0);
        set_req(0, 1'b0, D, 8'd32, 1'b1);
        tick();
        chk("idle_valid", 32'(rsp_valid), 32'd0);

        // Fairness from reset: all four valid continuously
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 8'd0, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            exp_id = c % 4;
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << exp_id));
            tick();
            chk("rr_id", 32'(rsp_id), 32'(exp_id));
            chk("rr_data", rsp_data, 32'h100 + 32'(exp_id));
        end

        // Only requester 3 valid (pointer at 2): grant 3, pointer wraps to 0
        req_valid = 4'b1000;
        #1;
        chk("only3_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("only3_id", 32'(rsp_id), 32'd3);

        // Backpressure: 1 and 2 pending, output stalled for 5 cycles
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_data", rsp_data, 32'h103);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel1_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("bp_rel1_id", 32'(rsp_id), 32'd1);
        chk("bp_rel1_data", rsp_data, 32'h101);
        chk("bp_rel2_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("bp_rel2_id", 32'(rsp_id), 32'd2);
        chk("bp_rel2_valid", 32'(rsp_valid), 32'd1);

        // Reset mid-stream while FULL with 1 and 3 pending (pointer at 3)
        req_valid = 4'b1010;
        rst       = 1'b1;
        #1;
        chk("mrst_ready", 32'(req_ready), 32'd0);
        tick();
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_data", rsp_data, 32'd0);
        chk("mrst_ready2", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst_first", 32'(req_ready), 32'b0010);
        tick();
        chk("mrst_id", 32'(rsp_id), 32'd1);
        chk("mrst_vld", 32'(rsp_valid), 32'd1);

        // Sparse traffic with pointer at 0
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("sp3_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("sp3_id", 32'(rsp_id), 32'd3);
        req_valid = '0;
        #1;
        chk("sp_none_ready", 32'(req_ready), 32'd0);
        tick();
        chk("sp_empty", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1001;
        #1;
        chk("sp03_ready0", 32'(req_ready), 32'b0001);
        tick();
        chk("sp03_id0", 32'(rsp_id), 32'd0);
        chk("sp03_data0", rsp_data, 32'h100);
        chk("sp03_ready3", 32'(req_ready), 32'b1000);
        tick();
        chk("sp03_id3", 32'(rsp_id), 32'd3);
        req_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the shifter (2..8).
REQ-002 Parameter: WIDTH, 32, data width in bits (power of two, 8..64).
REQ-003 Parameter: AMT_W, 8, width of each requested shift amount.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: req_valid  input  N_REQ  per-requester request valid.
REQ-007 Port: req_ready  output  N_REQ  per-requester accept; at most one bit set per cycle.
REQ-008 Port: req_data  input  N_REQ x WIDTH  per-requester operand.
REQ-009 Port: req_amt  input  N_REQ x AMT_W  per-requester rotate amount.
REQ-010 Port: req_dir  input  N_REQ  per-requester direction; 0 = rotate left, 1 = rotate right.
REQ-011 Port: rsp_valid  output  1  result register holds a valid result.
REQ-012 Port: rsp_ready  input  1  downstream accepts the result.
REQ-013 Port: rsp_data  output  WIDTH  rotated result.
REQ-014 Port: rsp_id  output  clog2(N_REQ)  index of the requester that issued the result.

Function
REQ-015 Transfer rule: a request transfers when req_valid[i] and req_ready[i] are both high on a rising edge; a response transfers when rsp_valid and rsp_ready are both high.
REQ-016 Issue condition: a grant is possible in a cycle only when slot_free = !rsp_valid | rsp_ready.
REQ-017 Arbitration: round-robin; search starts at pointer rr_ptr and proceeds upward with wrap. The first requester with req_valid set is granted.
REQ-018 req_ready[g] is combinationally high only for the granted index g, and only when slot_free is true. No requester valid means no ready bits set.
REQ-019 After a grant to g, rr_ptr becomes (g+1) mod N_REQ. With no grant, rr_ptr holds.
REQ-020 Latency: a result is registered on the grant edge; rsp_valid rises the cycle after the request transfer. There are no bubbles under back-to-back traffic with rsp_ready=1, giving a throughput of 1 per cycle.
REQ-021 Effective amount: req_amt mod WIDTH, i.e. its low clog2(WIDTH) bits. An amount of 0, or any multiple of WIDTH, returns the data unchanged.
REQ-022 Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_data, rsp_id and rsp_valid hold and all req_ready bits are 0.
REQ-023 Drain and refill: when rsp_ready=1 in the same cycle as a new grant, the register is overwritten with the new result and rsp_valid stays 1.
REQ-024 Idle drain: when rsp_ready=1 and no grant occurs, rsp_valid clears next cycle and rsp_data/rsp_id hold their last values.
REQ-025 Control states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY to FULL on a grant.
  - FULL to EMPTY on drain without a grant.
  - FULL stays FULL on drain with a grant, or on stall.
REQ-026 Requester inputs are sampled only on that requester's grant edge. Changes at other times have no effect.
REQ-027 A requester that drops req_valid before being granted is skipped without penalty.

Reset
REQ-028 While rst=1 at a rising edge, the block loads: rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0.
REQ-029 While rst=1, req_ready is forced to all zeros, regardless of req_valid.
REQ-030 Reset asserted mid-operation discards any held result; the first grant after rst deasserts goes to the lowest valid index.

Structure
REQ-031 Package shift_arbiter_pkg holds the default WIDTH, N_REQ and AMT_W constants and enum dir_e {DIR_LEFT=0, DIR_RIGHT=1}.
REQ-032 The rotation is a separate combinational sub-module barrel_rotate (WIDTH, data, amt, dir -> result), built as clog2(WIDTH) mux stages and instantiated once.
REQ-033 The arbiter, the output register and the control FSM reside in shift_arbiter.

Verification
REQ-034 Rotation check: requester 0 sends data=0x23832CD0, amt=4, dir=0 with rsp_ready=1. Required: rsp_data=0x3832CD02, rsp_id=0, rsp_valid=1 exactly one cycle later.
REQ-035 Direction and modulo check on data=0x23832CD0:
  - amt=8, dir=1 gives 0xD023832C.
  - amt=36, dir=0 gives 0x3832CD02.
  - amt=0 or amt=32 gives 0x23832CD0.
REQ-036 Fairness: all four requesters hold req_valid continuously with rsp_ready=1 from reset. Required: rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one req_ready bit high per cycle.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles while rsp_valid=1 and requesters 1 and 2 are valid. Required: rsp_data/rsp_id stable and req_ready=0 throughout; on rsp_ready=1, requester 1 is granted the same cycle and requester 2 the following cycle.
REQ-038 Sparse traffic: only requester 3 is valid, with the pointer at 0. Required: immediate grant to 3, then rr_ptr=0; a later simultaneous request from 0 and 3 grants 0 first.
REQ-039 Reset mid-stream: rst=1 for one cycle while FULL with traffic pending. Required: rsp_valid=0 and req_ready=0 in the reset cycle; the next grant goes to the lowest valid index.
